// File: rtl/seq_mul_nxn.sv
// Sequential radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with a start/busy/done handshake.
// Optional two's-complement mode enabled by defining SEQ_MUL_SIGNED_EN (adds the is_signed port).
module seq_mul_nxn #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand, acc, acc_sum, acc_final;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic                 accept, last;
  logic [WIDTH-1:0]     a_cap, b_cap;
  logic                 neg_cap;

`ifdef SEQ_MUL_SIGNED_EN
  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  always_comb begin
    a_cap   = (is_signed && a[WIDTH-1]) ? -a : a;
    b_cap   = (is_signed && b[WIDTH-1]) ? -b : b;
    neg_cap = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  end
`else
  always_comb begin
    a_cap   = a;
    b_cap   = b;
    neg_cap = 1'b0;
  end
`endif

  assign last      = (cnt == CNT_W'(WIDTH - 1));
  assign acc_sum   = mplier[0] ? (acc + mcand) : acc;
  assign acc_final = neg ? -acc_sum : acc_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a_cap};
      mplier <= b_cap;
      acc    <= '0;
      cnt    <= '0;
      neg    <= neg_cap;
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      // product only ever sees the completed sum
      if (last) product <= acc_final;
    end
  end

endmodule

// File: doc/seq_mul_nxn.md
Name: seq_mul_nxn

Overview:
- Parametrised sequential radix-2 shift-add multiplier: WIDTH x WIDTH operands give a 2*WIDTH product.
- Uses a start/busy/done handshake, so it trades latency for area against the existing combinational array multipliers.
- Used wherever the datapath can tolerate multi-cycle latency, e.g. scaling units behind a register file.
- The product is held stable until the next operation is accepted.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a multiply; sampled on the rising edge of clk.
- a  input  WIDTH  multiplicand; captured only when start is accepted.
- b  input  WIDTH  multiplier; captured only when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when the product becomes valid.
- product  output  2*WIDTH  result; held until the next accepted start.
- is_signed  input  1  present only when SEQ_MUL_SIGNED_EN is defined (see Optional Feature).

Behaviour:
- Reset and clocking:
  - One clock.
  - Reset is synchronous and active-low: rst_n is sampled on the rising edge of clk.
  - Reset values: state=IDLE, busy=0, done=0, product=0, internal registers=0.
- States:
  - IDLE: busy=0. If start=1, capture a into mcand (zero-extended to 2*WIDTH), capture b into mplier, clear acc and cnt, and go to RUN.
  - RUN: busy=1. Each cycle:
    - if mplier[0]=1 then acc <= acc + mcand;
    - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
    - When cnt = WIDTH-1 the final iteration executes, product <= final acc, and the block goes to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle.
    - start=1 in this cycle is accepted exactly as in IDLE and the block goes straight to RUN.
    - Otherwise the block goes to IDLE.
- Latency:
  - start accepted at edge k. RUN occupies edges k+1..k+WIDTH. done is high in the cycle following edge k+WIDTH.
  - Total: WIDTH+1 cycles from accept to done.
  - Throughput: one result per WIDTH+1 cycles when start is held high.
- start while busy=1 is ignored. Operands are not recaptured and the in-flight result is unaffected.
- product changes only at the transition from RUN to DONE. It never shows partial sums and stays constant through IDLE.
- Arithmetic:
  - acc is 2*WIDTH bits and can never overflow, since the maximum is (2^W-1)^2.
  - Zero operands still take the full latency; there is no early termination.
- rst_n=0 mid-operation: at the next edge the block aborts to IDLE, product=0, and no done pulse is issued.
- start and rst_n=0 in the same cycle: reset wins and start is dropped.
- a and b may change freely after acceptance.

Optional Feature:
- Macro: SEQ_MUL_SIGNED_EN.
- Defined:
  - The is_signed port exists.
  - When a start is accepted with is_signed=1, a and b are two's-complement. The block captures |a| and |b| as WIDTH-bit unsigned magnitudes and registers neg = a[W-1]^b[W-1].
  - The unsigned core runs unchanged. At the RUN to DONE transition, product <= neg ? -acc : acc (2*WIDTH two's-complement).
  - Latency is identical to unsigned mode.
  - -2^(W-1) is handled exactly: the magnitude 2^(W-1) fits in WIDTH unsigned bits.
  - When a start is accepted with is_signed=0, behaviour is identical to the unsigned build.
- Undefined: the port is absent and all operands are unsigned.

Test Plan:
- WIDTH=8: a=15, b=13, start pulse -> busy high for 8 cycles, done pulses 9 cycles after accept, product=16'h00C3; product still 16'h00C3 ten cycles later.
- WIDTH=8: a=255, b=255 -> product=16'hFE01. Then a=0, b=200 -> product=16'h0000 after the full 9-cycle latency.
- WIDTH=8, start held high, operand pairs (3,4) then (7,9) -> done pulses 9 cycles apart, product 12 then 63. A start asserted during RUN with different a, b does not alter the result.
- WIDTH=8: rst_n=0 for one cycle at the 4th RUN cycle of 100*100 -> busy=0 and product=0 the next cycle, no done pulse. A subsequent 2*3 gives 6.
- WIDTH=4 and WIDTH=16 builds: exhaustive (4-bit) and random 1000-pair (16-bit) checks against the a*b reference model; latency equals WIDTH+1 in every case.
- SEQ_MUL_SIGNED_EN, WIDTH=8, is_signed=1:
  - -3*5 -> 16'hFFF1
  - -128*-128 -> 16'h4000
  - -128*127 -> 16'hC080
  - with is_signed=0, 8'hFD*5 -> 16'h04F1.
